// File: rtl/psum_collector_if.sv
// psum_collector_if: drain-side valid/ready bus of the psum collector.
// master drives out_valid/out_data/out_lane/out_last; slave drives out_ready.
`timescale 1ns/1ps

interface psum_collector_if #(
  parameter int ACC_WIDTH = 24
);
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [1:0]           out_lane;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_lane,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_lane,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: accumulates 4-lane psum vectors over len valid cycles, then
// drains 4 lane words (or one merged word) over drn. Ports: clk, rst_n, start,
// len, signed_mode, merge, psum_fwd, psum_valid, busy, drn (master).
// Option PSUM_COLLECTOR_SAT_EN: saturating sums plus sticky sat_flag output.
`timescale 1ns/1ps

module psum_collector #(
  parameter int COL_WIDTH = 9,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   len,
  input  logic                   signed_mode,
  input  logic                   merge,
  input  logic [4*COL_WIDTH-1:0] psum_fwd,
  input  logic                   psum_valid,
  output logic                   busy,
`ifdef PSUM_COLLECTOR_SAT_EN
  output logic                   sat_flag,
`endif
  psum_collector_if.master       drn
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc     [4];
  logic [ACC_WIDTH-1:0] acc_nxt [4];
  logic [ACC_WIDTH-1:0] msum_nxt;
  logic [LEN_WIDTH-1:0] count;
  logic                 sgn;
  logic                 mrg;

  function automatic logic [ACC_WIDTH-1:0] ext(
    input logic [COL_WIDTH-1:0] v,
    input logic                 sg
  );
    logic f;
    f = sg & v[COL_WIDTH-1];
    return {{(ACC_WIDTH-COL_WIDTH){f}}, v};
  endfunction

`ifdef PSUM_COLLECTOR_SAT_EN
  // Three guard bits hold the exact sum of four accumulators.
  localparam int WW = ACC_WIDTH + 3;
  typedef logic signed [WW-1:0] wide_t;

  localparam wide_t SMAX =
    wide_t'((WW'(1) << (ACC_WIDTH - 1)) - WW'(1));
  localparam wide_t SMIN = -SMAX - wide_t'(1);
  localparam wide_t UMAX =
    wide_t'((WW'(1) << ACC_WIDTH) - WW'(1));

  function automatic wide_t widen(
    input logic [ACC_WIDTH-1:0] v,
    input logic                 sg
  );
    logic f;
    f = sg & v[ACC_WIDTH-1];
    return wide_t'({{3{f}}, v});
  endfunction

  // Returns {clamped, value}.
  function automatic logic [ACC_WIDTH:0] clamp(
    input wide_t s,
    input logic  sg
  );
    wide_t hi;
    wide_t lo;
    hi = sg ? SMAX : UMAX;
    lo = sg ? SMIN : '0;
    if (s > hi) return {1'b1, ACC_WIDTH'(hi)};
    if (s < lo) return {1'b1, ACC_WIDTH'(lo)};
    return {1'b0, ACC_WIDTH'(s)};
  endfunction

  wide_t lsum [4];
  wide_t msum;
  logic  lsat [4];
  logic  msat;
  logic  sat_hit;

  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lsum[i] = widen(acc[i], sgn) +
        widen(ext(psum_fwd[i*COL_WIDTH +: COL_WIDTH], sgn), sgn);
      {lsat[i], acc_nxt[i]} = clamp(lsum[i], sgn);
      sat_hit = sat_hit | lsat[i];
    end
    msum = widen(acc_nxt[0], sgn) + widen(acc_nxt[1], sgn) +
      widen(acc_nxt[2], sgn) + widen(acc_nxt[3], sgn);
    {msat, msum_nxt} = clamp(msum, sgn);
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_nxt[i] = acc[i] +
        ext(psum_fwd[i*COL_WIDTH +: COL_WIDTH], sgn);
    end
    msum_nxt = acc_nxt[0] + acc_nxt[1] + acc_nxt[2] + acc_nxt[3];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      count         <= '0;
      sgn           <= 1'b0;
      mrg           <= 1'b0;
      busy          <= 1'b0;
      drn.out_valid <= 1'b0;
      drn.out_data  <= '0;
      drn.out_lane  <= '0;
      drn.out_last  <= 1'b0;
`ifdef PSUM_COLLECTOR_SAT_EN
      sat_flag      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sgn   <= signed_mode;
            mrg   <= merge;
            count <= len;
            busy  <= 1'b1;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
`ifdef PSUM_COLLECTOR_SAT_EN
            sat_flag <= 1'b0;
`endif
            if (len == '0) begin
              // Empty job: drain zeros straight away.
              state         <= DRAIN;
              drn.out_valid <= 1'b1;
              drn.out_data  <= '0;
              drn.out_lane  <= '0;
              drn.out_last  <= merge;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (psum_valid) begin
            for (int i = 0; i < 4; i++) acc[i] <= acc_nxt[i];
            count <= count - LEN_WIDTH'(1);
`ifdef PSUM_COLLECTOR_SAT_EN
            sat_flag <= sat_flag | sat_hit;
`endif
            if (count == LEN_WIDTH'(1)) begin
              // Present the first word from the
              // final sums so it appears next cycle.
              state         <= DRAIN;
              drn.out_valid <= 1'b1;
              drn.out_lane  <= '0;
              drn.out_last  <= mrg;
              drn.out_data  <= mrg ? msum_nxt : acc_nxt[0];
`ifdef PSUM_COLLECTOR_SAT_EN
              sat_flag <= sat_flag | sat_hit | (mrg & msat);
`endif
            end
          end
        end
        DRAIN: begin
          if (drn.out_ready) begin
            if (drn.out_last) begin
              state         <= IDLE;
              busy          <= 1'b0;
              drn.out_valid <= 1'b0;
              drn.out_data  <= '0;
              drn.out_lane  <= '0;
              drn.out_last  <= 1'b0;
            end else begin
              drn.out_lane <= drn.out_lane + 2'd1;
              drn.out_data <= acc[drn.out_lane + 2'd1];
              drn.out_last <= (drn.out_lane == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed plus random jobs on two collectors
// (24-bit and 10-bit accumulators) checked against an arithmetic model.
`timescale 1ns/1ps

module tb_psum_collector;
  localparam int COLW = 9;
  localparam int LENW = 8;
  localparam int AW0  = 24;
  localparam int AW1  = 10;
`ifdef PSUM_COLLECTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [LENW-1:0] len   = '0;
  logic            sgm   = 1'b0;
  logic            mrgm  = 1'b0;
  logic [4*COLW-1:0] pf  = '0;
  logic            pv    = 1'b0;
  logic            rdy   = 1'b0;
  logic            busy0;
  logic            busy1;
`ifdef PSUM_COLLECTOR_SAT_EN
  logic            sat0;
  logic            sat1;
`endif

  psum_collector_if #(.ACC_WIDTH(AW0)) d0 ();
  psum_collector_if #(.ACC_WIDTH(AW1)) d1 ();
  assign d0.out_ready = rdy;
  assign d1.out_ready = rdy;

  always #5 clk = ~clk;

  psum_collector #(
    .COL_WIDTH(COLW), .ACC_WIDTH(AW0), .LEN_WIDTH(LENW)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .signed_mode(sgm), .merge(mrgm), .psum_fwd(pf),
    .psum_valid(pv), .busy(busy0),
`ifdef PSUM_COLLECTOR_SAT_EN
    .sat_flag(sat0),
`endif
    .drn(d0)
  );

  psum_collector #(
    .COL_WIDTH(COLW), .ACC_WIDTH(AW1), .LEN_WIDTH(LENW)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .signed_mode(sgm), .merge(mrgm), .psum_fwd(pf),
    .psum_valid(pv), .busy(busy1),
`ifdef PSUM_COLLECTOR_SAT_EN
    .sat_flag(sat1),
`endif
    .drn(d1)
  );

  int total = 0;
  int bad   = 0;

  logic [4*COLW-1:0] vq [$];
  longint exp0 [$];
  longint exp1 [$];
  bit exph0;
  bit exph1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint lane_val(logic [4*COLW-1:0] v, int i,
                                      bit sg);
    logic [COLW-1:0] x;
    x = v[i*COLW +: COLW];
    return sg ? longint'($signed(x)) : longint'(x);
  endfunction

  // Wrap modulo 2^w, or clamp to the representable range.
  function automatic longint fold(longint v, int w, bit sg);
    longint m;
    longint lo;
    longint hi;
    m = longint'(1) << w;
    if (SAT) begin
      lo = sg ? -(m >> 1) : 0;
      hi = sg ? (m >> 1) - 1 : m - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
    end
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [63:0] mask(longint e, int w);
    return 64'(e & ((longint'(1) << w) - 1));
  endfunction

  task automatic model_job(input bit sg, input bit mg);
    longint a [2][4];
    int     w [2];
    bit     h [2];
    longint nv;
    longint f;
    w[0] = AW0;
    w[1] = AW1;
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 2; k++) begin
      h[k] = 1'b0;
      for (int i = 0; i < 4; i++) a[k][i] = 0;
    end
    foreach (vq[j]) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          nv = a[k][i] + lane_val(vq[j], i, sg);
          f  = fold(nv, w[k], sg);
          if (SAT && f != nv) h[k] = 1'b1;
          a[k][i] = f;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (mg) begin
        nv = a[k][0] + a[k][1] + a[k][2] + a[k][3];
        f  = fold(nv, w[k], sg);
        if (SAT && f != nv) h[k] = 1'b1;
        if (k == 0) exp0.push_back(f);
        else exp1.push_back(f);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (k == 0) exp0.push_back(a[k][i]);
          else exp1.push_back(a[k][i]);
        end
      end
    end
    exph0 = h[0];
    exph1 = h[1];
  endtask

  // gapmode 0: back to back, 1: 1,0,1,0 valid, 2: random gaps.
  // rdymode 0: ready high, 1: random, 2: 3 stall cycles on lane 1.
  task automatic run_job(input int n, input bit sg, input bit mg,
                         input int gapmode, input int rdymode,
                         input bit poke, input string tag);
    int got;
    int cyc;
    int nexp;
    int stall_left;
    model_job(sg, mg);
    nexp = exp0.size();
    start = 1'b1;
    len   = LENW'(n);
    sgm   = sg;
    mrgm  = mg;
    @(posedge clk); #1;
    start = 1'b0;
    len   = LENW'($urandom);
    sgm   = ~sg;
    mrgm  = ~mg;
    chk({tag, "_busy_start"}, 64'(busy0), 64'(1));
    for (int j = 0; j < n; j++) begin
      if ((gapmode == 1 && j > 0) ||
          (gapmode == 2 && $urandom_range(0, 2) == 0)) begin
        pv = 1'b0;
        pf = (4*COLW)'({$urandom(), $urandom()});
        if (poke && j == 1) begin
          start = 1'b1;
          len   = LENW'(7);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_gap"}, 64'(busy0), 64'(1));
      end
      pv = 1'b1;
      pf = vq[j];
      @(posedge clk); #1;
      pv = 1'b0;
      pf = (4*COLW)'({$urandom(), $urandom()});
    end
    chk({tag, "_latency_valid"}, 64'(d0.out_valid), 64'(1));
    got = 0;
    cyc = 0;
    stall_left = (rdymode == 2) ? 3 : 0;
    while (got < nexp && cyc < 200) begin
      if (rdymode == 1) begin
        rdy = 1'($urandom_range(0, 1));
      end else if (rdymode == 2 && d0.out_lane == 2'd1 &&
                   stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = 1'b1;
      end
      pv = 1'($urandom_range(0, 1));
      pf = (4*COLW)'({$urandom(), $urandom()});
      chk({tag, "_valid"}, 64'(d0.out_valid), 64'(1));
      chk({tag, "_data24"}, 64'(d0.out_data), mask(exp0[got], AW0));
      chk({tag, "_data10"}, 64'(d1.out_data), mask(exp1[got], AW1));
      chk({tag, "_lane"}, 64'(d0.out_lane), mg ? 64'(0) : 64'(got));
      chk({tag, "_last"}, 64'(d0.out_last), 64'(got == nexp - 1));
      if (rdy) got++;
      if (rdy && got == nexp && poke) begin
        start = 1'b1;
        len   = LENW'(5);
      end
      cyc++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    pv  = 1'b0;
    rdy = 1'b0;
    if (got < nexp) chk({tag, "_drain_timeout"}, 64'(got), 64'(nexp));
    chk({tag, "_busy_end"}, 64'(busy0), 64'(0));
    chk({tag, "_busy_end10"}, 64'(busy1), 64'(0));
    chk({tag, "_valid_end"}, 64'(d0.out_valid), 64'(0));
`ifdef PSUM_COLLECTOR_SAT_EN
    chk({tag, "_sat24"}, 64'(sat0), 64'(exph0));
    chk({tag, "_sat10"}, 64'(sat1), 64'(exph1));
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy0), 64'(0));
    chk({tag, "_busy10"}, 64'(busy1), 64'(0));
    chk({tag, "_valid"}, 64'(d0.out_valid), 64'(0));
    chk({tag, "_data"}, 64'(d0.out_data), 64'(0));
    chk({tag, "_lane"}, 64'(d0.out_lane), 64'(0));
    chk({tag, "_last"}, 64'(d0.out_last), 64'(0));
`ifdef PSUM_COLLECTOR_SAT_EN
    chk({tag, "_sat"}, 64'(sat0), 64'(0));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit sg;
    bit mg;
    #1 rst_n = 1'b0;
    #1 chk_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of accumulation.
    start = 1'b1;
    len   = LENW'(5);
    sgm   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      pv = 1'b1;
      pf = {4{9'd100}};
      @(posedge clk); #1;
    end
    pv = 1'b0;
    rst_n = 1'b0;
    #1 chk_idle("midreset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vq = '{{9'd4, 9'd3, 9'd2, 9'd1}};
    run_job(1, 1'b0, 1'b0, 0, 0, 1'b0, "after_reset");

    vq = '{{4{9'h1FF}}, {4{9'h1FF}}, {4{9'h1FF}}};
    run_job(3, 1'b1, 1'b0, 0, 0, 1'b0, "signed");

    vq = '{{9'd3, 9'd2, 9'd1, 9'd511}, {9'd3, 9'd2, 9'd1, 9'd511}};
    run_job(2, 1'b0, 1'b1, 0, 0, 1'b0, "merge");

    vq.delete();
    for (int j = 0; j < 4; j++)
      vq.push_back((4*COLW)'({$urandom(), $urandom()}));
    run_job(4, 1'b1, 1'b0, 1, 2, 1'b1, "gaps_stall");

    vq.delete();
    run_job(0, 1'b0, 1'b0, 0, 0, 1'b0, "len0");
    run_job(0, 1'b1, 1'b1, 0, 1, 1'b0, "len0_merge");

    vq = '{{27'd0, 9'd511}, {27'd0, 9'd511}, {27'd0, 9'd511}};
    run_job(3, 1'b0, 1'b0, 0, 0, 1'b0, "wrap_u");

    vq = '{{27'd0, 9'h100}, {27'd0, 9'h100}, {27'd0, 9'h100}};
    run_job(3, 1'b1, 1'b1, 0, 0, 1'b0, "wrap_s");

    for (int r = 0; r < 12; r++) begin
      n  = $urandom_range(0, 12);
      sg = 1'($urandom_range(0, 1));
      mg = 1'($urandom_range(0, 1));
      vq.delete();
      for (int j = 0; j < n; j++)
        vq.push_back((4*COLW)'({$urandom(), $urandom()}));
      run_job(n, sg, mg, 2, 1, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Consumer at the output end of a fusion-unit column. Receives the packed 4-lane partial-sum vector (psum_fwd) a fusion unit produces each cycle.
- Sign-extends each lane and accumulates it over a programmed number of valid vectors.
- Then drains the results one word per cycle over a valid/ready interface to the output buffer.
- Fills the result-side gap: the fusion unit forwards psums but has no reduction or drain path.

Parameters:
- COL_WIDTH, 9, width of one psum lane in psum_fwd (4 lanes packed, lane 0 in LSBs).
- ACC_WIDTH, 24, width of each lane accumulator and of out_data; must be >= COL_WIDTH+1.
- LEN_WIDTH, 8, width of the accumulation-length field.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a new accumulation job; sampled only in IDLE.
- len  input  LEN_WIDTH  number of psum vectors to accumulate; sampled with start.
- signed_mode  input  1  1: lanes are two's complement; 0: unsigned. Sampled with start.
- merge  input  1  1: emit a single word (sum of the 4 lane accumulators); 0: emit 4 words. Sampled with start.
- psum_fwd  input  COL_WIDTH*4  packed partial sums from the fusion unit.
- psum_valid  input  1  psum_fwd carries a valid vector this cycle.
- busy  output  1  high in ACCUM and DRAIN.
- out_valid  output  1  out_data/out_lane valid.
- out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
- out_data  output  ACC_WIDTH  accumulated result.
- out_lane  output  2  lane index of out_data; 0 when merge is set.
- out_last  output  1  high on the final word of a job.

Behaviour:
- Reset (async, rst_n low):
  - FSM returns to IDLE.
  - Accumulators, counter, latched mode bits and drain index are cleared.
  - busy=0, out_valid=0, out_data=0, out_lane=0, out_last=0.
  - Reset takes effect mid-job; the partial job is discarded and nothing is emitted.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1 latches len, signed_mode and merge, clears all 4 accumulators and loads count=len.
  - Next state is ACCUM if len!=0. If len==0, next state is DRAIN and the emitted results are 0.
  - psum_valid is ignored in IDLE.
- ACCUM:
  - Each cycle with psum_valid=1: acc[i] <= acc[i] + ext(lane i) for i=0..3.
  - ext = sign-extend when signed_mode=1, zero-extend otherwise, up to ACC_WIDTH.
  - Arithmetic wraps modulo 2^ACC_WIDTH (see optional feature).
  - count decrements per accepted vector. The vector that takes count from 1 to 0 is included, and the next state is DRAIN.
  - Cycles with psum_valid=0 cause no change.
  - start is ignored while busy.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle; result latency is 1 cycle after the last vector is accepted.
  - merge=0: words are emitted for lane 0,1,2,3 in order. out_data=acc[idx] and out_lane=idx. idx advances only on handshake.
  - merge=1: one word is emitted, out_data = acc0+acc1+acc2+acc3 (modulo 2^ACC_WIDTH), with out_lane=0.
  - out_last=1 on the final word.
  - out_data, out_lane and out_last hold stable while out_valid=1 and out_ready=0.
  - psum_valid is ignored in DRAIN; the upstream must not issue vectors then.
  - Handshake on the final word returns the FSM to IDLE. busy and out_valid fall the next cycle.
  - A start asserted in that same cycle is ignored; start is accepted only while the FSM is in IDLE.
- Throughput: with out_ready tied high, a job takes len + 4 cycles after start (non-merge) or len + 1 cycles (merge), plus 1 cycle in IDLE.

Optional Feature:
- Macro: PSUM_COLLECTOR_SAT_EN.
- Defined: each lane accumulation and the merge sum saturate instead of wrapping.
  - signed_mode=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - signed_mode=0: clamp to [0, 2^ACC_WIDTH-1].
  - A sticky per-job flag sets when any clamp occurs. It is driven on an extra output port sat_flag (1 bit), cleared on start and on reset.
- Undefined: modulo wrap, and no sat_flag port exists.

Test Plan:
- Reset: assert rst_n=0 mid-ACCUM (after 2 of len=5 vectors) -> all outputs 0 immediately. A following start with len=1 and lane values {4,3,2,1} yields words 1,2,3,4 with no residue.
- Signed accumulate: signed_mode=1, len=3, every lane 9'h1FF each cycle, out_ready=1 -> 4 words each 24'hFFFFFD (-3), out_lane 0..3, out_last on lane 3, busy low 1 cycle after.
- Unsigned + merge: signed_mode=0, merge=1, len=2, lanes {511,1,2,3} both cycles -> single word 1034, out_lane=0, out_last=1.
- Gaps and backpressure: len=4 with psum_valid toggling 1,0,1,0,... and out_ready low for 3 cycles on lane 1 -> correct sums. out_data stays stable while stalled. A start pulse during busy is ignored.
- len=0: start, len=0 -> DRAIN next cycle, four words of 0, last flagged.
- Wrap/saturate: ACC_WIDTH=10, unsigned, len=3, lane 0=511 -> without macro out_data=509 (1533 mod 1024); with PSUM_COLLECTOR_SAT_EN out_data=1023 and sat_flag=1.
